dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-requester (cpu / host) arbiter in front of a single-port
//               synchronous data RAM with 1-cycle read latency. Each access
//               runs IDLE -> ACCESS -> RESP, so ack is fixed at 2 cycles
//               after the request is sampled. Misaligned requests are acked
//               with zero data and never reach the RAM. Simultaneous requests
//               are counted in a saturating 16-bit conflict counter.
// Option      : DMEM_ARB_ROUND_ROBIN_EN -- alternate winners on conflict;
//               when undefined, cpu always wins a conflict.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // processor port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // loader / debug port
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  // RAM port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // statistics
  output logic [15:0]       conflicts
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_HOST = 1'b1;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_owner;
  logic                r_we;
  logic                r_misaligned;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_host_rdata;
  logic [15:0]         r_conflicts;

  logic                w_any_req;
  logic                w_both_req;
  logic                w_grant_host;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [DATA_W-1:0]   w_resp_data;

  assign w_any_req  = cpu_req | host_req;
  assign w_both_req = cpu_req & host_req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // r_prio_host = 1 means host wins the next conflict (i.e. cpu was last owner)
  logic r_prio_host;

  // Remember the last owner on every grant; reset favours cpu
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio_host <= 1'b0;
    end else if (r_state == IDLE && w_any_req) begin
      r_prio_host <= ~w_grant_host;
    end
  end

  assign w_grant_host = host_req & (~cpu_req | r_prio_host);
`else
  assign w_grant_host = host_req & ~cpu_req;
`endif

  assign w_sel_we    = w_grant_host ? host_we    : cpu_we;
  assign w_sel_addr  = w_grant_host ? host_addr  : cpu_addr;
  assign w_sel_wdata = w_grant_host ? host_wdata : cpu_wdata;

  // Writes and misaligned accesses return zero instead of RAM data
  assign w_resp_data = (r_we || r_misaligned) ? '0 : mem_rdata;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state outputs; acks/enables derive from state so reset kills them at once
  always_comb begin
    w_state_nxt = r_state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    cpu_ack     = 1'b0;
    host_ack    = 1'b0;
    cpu_rdata   = r_cpu_rdata;
    host_rdata  = r_host_rdata;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_en      = ~r_misaligned;
        mem_we      = r_we & ~r_misaligned;
        w_state_nxt = RESP;
      end
      RESP: begin
        if (r_owner == OWN_HOST) begin
          host_ack   = 1'b1;
          host_rdata = w_resp_data;
        end else begin
          cpu_ack    = 1'b1;
          cpu_rdata  = w_resp_data;
        end
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Latch the winning request in IDLE; hold response data after the ack cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner      <= OWN_CPU;
      r_we         <= 1'b0;
      r_misaligned <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      if (r_state == IDLE && w_any_req) begin
        r_owner      <= w_grant_host ? OWN_HOST : OWN_CPU;
        r_we         <= w_sel_we;
        r_misaligned <= |w_sel_addr[1:0];
        r_addr       <= w_sel_addr;
        r_wdata      <= w_sel_wdata;
      end
      if (r_state == RESP) begin
        if (r_owner == OWN_HOST) begin
          r_host_rdata <= w_resp_data;
        end else begin
          r_cpu_rdata  <= w_resp_data;
        end
      end
    end
  end

  // Saturating count of IDLE cycles where both requesters were asking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conflicts <= '0;
    end else if (r_state == IDLE && w_both_req && r_conflicts != CNT_MAX) begin
      r_conflicts <= r_conflicts + 16'd1;
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign conflicts = r_conflicts;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. A synchronous RAM model
//               sits on the memory port; a shadow memory plus a grant-policy
//               model predict read data, grant order and ack timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ack, cpu_stall;
  logic [31:0] cpu_rdata;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [31:0] host_addr = '0, host_wdata = '0;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] conflicts;

  int checks = 0;
  int failures = 0;

  // reference state
  logic [31:0] shadow [0:255];
  logic [31:0] exp_cpu_rd;
  logic [31:0] exp_host_rd;
  int          exp_conflicts;

  // RAM model (environment)
  logic [31:0] ram [0:255] = '{default: 32'h0};

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflicts(conflicts)
  );

  always #5 clk = ~clk;

  // synchronous RAM, one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[9:2]];
    end
  end

  // run one single-requester transaction and report what was observed
  task automatic issue(input bit host, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output bit wrong_ack,
                       output logic me, output logic mw, output logic [31:0] ma,
                       output logic [31:0] mwd, output logic st_acc, output logic st_ack);
    @(negedge clk);
    if (host) begin
      host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
    @(posedge clk);
    lat = -1; rd = '0; wrong_ack = 1'b0; me = 1'b0; mw = 1'b0; ma = '0; mwd = '0;
    st_acc = 1'b0; st_ack = 1'b0;
    for (int k = 1; k <= 6 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        me = mem_en; mw = mem_we; ma = mem_addr; mwd = mem_wdata; st_acc = cpu_stall;
      end
      if (host ? host_ack : cpu_ack) begin
        lat = k; rd = host ? host_rdata : cpu_rdata; st_ack = cpu_stall;
      end
      if (host ? cpu_ack : host_ack) wrong_ack = 1'b1;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; host_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if ({mem_en, mem_we, cpu_ack, host_ack, cpu_stall} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got en/we/cack/hack/stall=%b want 00000",
               {mem_en, mem_we, cpu_ack, host_ack, cpu_stall});
    end
    checks++;
    if (cpu_rdata !== 32'h0 || host_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got cpu=%h host=%h want 0", cpu_rdata, host_rdata);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || conflicts !== 16'h0) begin
      failures++;
      $display("FAIL reset_regs got addr=%h wdata=%h conf=%h want 0", mem_addr, mem_wdata, conflicts);
    end
    do_reset();
  endtask

  task automatic test_cpu_write();
    int lat; logic [31:0] rd, ma, mwd; bit wa; logic me, mw, sa, sk;
    issue(1'b0, 1'b1, 32'h64, 32'h7, lat, rd, wa, me, mw, ma, mwd, sa, sk);
    shadow[25] = 32'h7; exp_cpu_rd = 32'h0;
    checks++;
    if (me !== 1'b1 || mw !== 1'b1 || ma !== 32'h64 || mwd !== 32'h7) begin
      failures++;
      $display("FAIL cpu_write_mem got en=%b we=%b addr=%h wdata=%h want 1 1 64 7", me, mw, ma, mwd);
    end
    checks++;
    if (lat !== 2 || wa) begin
      failures++;
      $display("FAIL cpu_write_lat got lat=%0d wrong_ack=%0d want 2 0", lat, wa);
    end
    checks++;
    if (sa !== 1'b1 || sk !== 1'b0) begin
      failures++;
      $display("FAIL cpu_write_stall got access=%b ack=%b want 1 0", sa, sk);
    end
  endtask

  task automatic test_host_write_cpu_read();
    int lat; logic [31:0] rd, ma, mwd; bit wa; logic me, mw, sa, sk;
    issue(1'b1, 1'b1, 32'h60, 32'h2A, lat, rd, wa, me, mw, ma, mwd, sa, sk);
    shadow[24] = 32'h2A; exp_host_rd = 32'h0;
    checks++;
    if (lat !== 2 || wa || me !== 1'b1 || mw !== 1'b1 || ma !== 32'h60) begin
      failures++;
      $display("FAIL host_write got lat=%0d wrong_ack=%0d en=%b we=%b addr=%h want 2 0 1 1 60",
               lat, wa, me, mw, ma);
    end
    issue(1'b0, 1'b0, 32'h60, 32'h0, lat, rd, wa, me, mw, ma, mwd, sa, sk);
    exp_cpu_rd = 32'h2A;
    checks++;
    if (rd !== 32'h2A || lat !== 2) begin
      failures++;
      $display("FAIL cpu_read_after_host got rdata=%h lat=%0d want 2a 2", rd, lat);
    end
    checks++;
    if (wa || me !== 1'b1 || mw !== 1'b0) begin
      failures++;
      $display("FAIL cpu_read_side got host_ack_seen=%0d en=%b we=%b want 0 1 0", wa, me, mw);
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd, ma, mwd; bit wa; logic me, mw, sa, sk;
    issue(1'b0, 1'b0, 32'h66, 32'h0, lat, rd, wa, me, mw, ma, mwd, sa, sk);
    exp_cpu_rd = 32'h0;
    checks++;
    if (me !== 1'b0 || lat !== 2 || rd !== 32'h0 || wa) begin
      failures++;
      $display("FAIL misaligned_read got en=%b lat=%0d rdata=%h wrong_ack=%0d want 0 2 0 0", me, lat, rd, wa);
    end
    issue(1'b1, 1'b1, 32'h63, 32'hDEAD, lat, rd, wa, me, mw, ma, mwd, sa, sk);
    exp_host_rd = 32'h0;
    checks++;
    if (me !== 1'b0 || mw !== 1'b0 || lat !== 2) begin
      failures++;
      $display("FAIL misaligned_write got en=%b we=%b lat=%0d want 0 0 2", me, mw, lat);
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, ma, mwd; bit wa; logic me, mw, sa, sk;
    for (int n = 0; n < 40; n++) begin
      bit          host, we, mis;
      int          idx;
      logic [31:0] addr, wd, exp_rd;
      host = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      mis  = ($urandom_range(0, 7) == 0);
      idx  = $urandom_range(16, 31);
      addr = idx * 4 + (mis ? $urandom_range(1, 3) : 0);
      wd   = $urandom;
      exp_rd = (we || mis) ? 32'h0 : shadow[idx];
      if (we && !mis) shadow[idx] = wd;
      issue(host, we, addr, wd, lat, rd, wa, me, mw, ma, mwd, sa, sk);
      if (host) exp_host_rd = exp_rd; else exp_cpu_rd = exp_rd;
      checks++;
      if (lat !== 2 || wa || rd !== exp_rd) begin
        failures++;
        $display("FAIL rand_resp n=%0d got lat=%0d wrong_ack=%0d rdata=%h want 2 0 %h", n, lat, wa, rd, exp_rd);
      end
      checks++;
      if (me !== !mis || (!mis && (ma !== addr || mw !== we || (we && mwd !== wd)))) begin
        failures++;
        $display("FAIL rand_mem n=%0d got en=%b we=%b addr=%h wdata=%h want en=%b we=%b addr=%h wdata=%h",
                 n, me, mw, ma, mwd, !mis, we, addr, wd);
      end
      checks++;
      if (cpu_rdata !== exp_cpu_rd || host_rdata !== exp_host_rd) begin
        failures++;
        $display("FAIL rand_hold n=%0d got cpu=%h host=%h want %h %h", n, cpu_rdata, host_rdata,
                 exp_cpu_rd, exp_host_rd);
      end
    end
    checks++;
    if (conflicts !== 16'(exp_conflicts)) begin
      failures++;
      $display("FAIL rand_conflicts got %0d want %0d", conflicts, exp_conflicts);
    end
  endtask

  task automatic test_conflict();
    bit winner_host [0:3];
    bit prio_host;
    do_reset();
    exp_conflicts = 0;
    prio_host = 1'b0;
    for (int g = 0; g < 4; g++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      winner_host[g] = prio_host;
      prio_host = !prio_host;
`else
      winner_host[g] = 1'b0;
`endif
      exp_conflicts++;
    end
    // first rising edge after reset release samples these requests
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h60;
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h64;
    @(posedge clk);
    for (int k = 1; k <= 11; k++) begin
      logic [2:0] exp_v;
      bit ack_cyc;
      @(negedge clk);
      ack_cyc = (k % 3 == 2);
      exp_v = {ack_cyc && !winner_host[k / 3], ack_cyc && winner_host[k / 3],
               !(ack_cyc && !winner_host[k / 3])};
      checks++;
      if ({cpu_ack, host_ack, cpu_stall} !== exp_v) begin
        failures++;
        $display("FAIL conflict_cycle k=%0d got cack/hack/stall=%b want %b", k,
                 {cpu_ack, host_ack, cpu_stall}, exp_v);
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; host_req = 1'b0;
    checks++;
    if (conflicts !== 16'(exp_conflicts)) begin
      failures++;
      $display("FAIL conflict_count got %0d want %0d", conflicts, exp_conflicts);
    end
  endtask

  task automatic test_reset_mid_access();
    bit ack_seen;
    int lat;
    logic [31:0] rd;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h64; cpu_wdata = 32'h99;
    @(posedge clk); #1;
    checks++;
    if (mem_en !== 1'b1) begin
      failures++;
      $display("FAIL mid_access_en got %b want 1", mem_en);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || cpu_ack !== 1'b0 || conflicts !== 16'h0) begin
      failures++;
      $display("FAIL mid_access_reset got en=%b we=%b ack=%b conf=%0d want 0 0 0 0",
               mem_en, mem_we, cpu_ack, conflicts);
    end
    cpu_req = 1'b0;
    ack_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_ack) ack_seen = 1'b1;
    end
    checks++;
    if (ack_seen) begin
      failures++;
      $display("FAIL mid_access_noack got ack during reset want none");
    end
    // release reset with a re-issued read of the aborted write location
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h64;
    @(posedge clk);
    lat = -1; rd = '0;
    for (int k = 1; k <= 6 && lat < 0; k++) begin
      @(negedge clk);
      if (cpu_ack) begin lat = k; rd = cpu_rdata; end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    checks++;
    if (lat !== 2 || rd !== shadow[25]) begin
      failures++;
      $display("FAIL mid_access_reissue got lat=%0d rdata=%h want 2 %h", lat, rd, shadow[25]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 32'h0;
    exp_cpu_rd = '0; exp_host_rd = '0; exp_conflicts = 0;
    test_reset();
    test_cpu_write();
    test_host_write_cpu_read();
    test_misaligned();
    test_random();
    test_conflict();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
